// File: rtl/md_sched.sv
// Multiply/divide scheduler for the MIPS core: owns HI/LO, models fixed MD latency
// with a down-counter, and raises stall_md for D-stage MD instructions while busy.
module md_sched #(
  parameter int MULT_CYCLES = 5,  // must be >= 1
  parameter int DIV_CYCLES  = 10  // must be >= 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [2:0]  md_op_i,
  input  logic [31:0] rs_val_i,
  input  logic [31:0] rt_val_i,
  input  logic        md_use_d_i,
  output logic        busy_o,
  output logic        stall_md_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  // state   | meaning
  // ST_IDLE | no operation pending; start accepted, mthi/mtlo write directly
  // ST_RUN  | result held in pending regs, counting down to HI/LO write-back
  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               div_zero;
  logic [31:0]        divisor_nz;
  logic [31:0]        quo_u, rem_u;
  logic [31:0]        mag_a, mag_b, quo_mag, rem_mag, quo_s, rem_s;

  assign prod_s = $signed({{32{rs_val_i[31]}}, rs_val_i}) * $signed({{32{rt_val_i[31]}}, rt_val_i});
  assign prod_u = {32'd0, rs_val_i} * {32'd0, rt_val_i};

  // Divisor forced non-zero so the dividers never see 0; the zero case is muxed out below.
  assign div_zero   = (rt_val_i == 32'd0);
  assign divisor_nz = div_zero ? 32'd1 : rt_val_i;
  assign quo_u      = rs_val_i / divisor_nz;
  assign rem_u      = rs_val_i % divisor_nz;

  // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000 naturally.
  assign mag_a   = rs_val_i[31] ? (32'd0 - rs_val_i) : rs_val_i;
  assign mag_b   = divisor_nz[31] ? (32'd0 - divisor_nz) : divisor_nz;
  assign quo_mag = mag_a / mag_b;
  assign rem_mag = mag_a % mag_b;
  assign quo_s   = (rs_val_i[31] ^ divisor_nz[31]) ? (32'd0 - quo_mag) : quo_mag;
  assign rem_s   = rs_val_i[31] ? (32'd0 - rem_mag) : rem_mag;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          case (md_op_i)
            OP_MULT: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = ST_RUN;
            end
            OP_MULTU: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = ST_RUN;
            end
            OP_DIV, OP_DIVU: begin
              if (div_zero) begin
                pend_hi_d = hi_q;
                pend_lo_d = lo_q;
              end else if (md_op_i == OP_DIV) begin
                pend_hi_d = rem_s;
                pend_lo_d = quo_s;
              end else begin
                pend_hi_d = rem_u;
                pend_lo_d = quo_u;
              end
              cnt_d   = CW'(DIV_CYCLES);
              state_d = ST_RUN;
            end
            OP_MTHI: hi_d = rs_val_i;
            OP_MTLO: lo_d = rs_val_i;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign busy_o     = (state_q == ST_RUN);
  assign stall_md_o = md_use_d_i & (start_i | busy_o);
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: arithmetic results, busy latency, stall gating,
// divide-by-zero, mid-operation reset and back-to-back issue.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        reset, start, md_use;
  logic [2:0]  md_op;
  logic [31:0] rs, rt;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .start_i    (start),
    .md_op_i    (md_op),
    .rs_val_i   (rs),
    .rt_val_i   (rt),
    .md_use_d_i (md_use),
    .busy_o     (busy),
    .stall_md_o (stall),
    .hi_o       (hi),
    .lo_o       (lo)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op in the current cycle and returns in the first cycle busy is low.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int nbusy, output bit held, output bit stall_ok);
    logic [31:0] hi0, lo0;
    hi0      = hi;
    lo0      = lo;
    held     = 1'b1;
    stall_ok = 1'b1;
    nbusy    = 0;
    start = 1'b1; md_op = op; rs = a; rt = b;
    #1;
    if (stall !== md_use) stall_ok = 1'b0;
    tick();
    start = 1'b0; md_op = 3'd0;
    #1;
    while (busy === 1'b1 && nbusy < 50) begin
      nbusy++;
      if (hi !== hi0 || lo !== lo0) held = 1'b0;
      if (stall !== md_use) stall_ok = 1'b0;
      tick();
    end
  endtask

  always @(negedge clk)
    if (start === 1'b1 && busy === 1'b1) check_eq("no_start_in_run", 32'd1, 32'd0);

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  held, sok, quiet;

    reset = 1'b1; start = 1'b0; md_op = 3'd0; rs = '0; rt = '0; md_use = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_hi", hi, 32'd0);
    check_eq("rst_lo", lo, 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);

    run_op(3'd1, 32'hFFFF_FFFD, 32'd5, n, held, sok);
    check_eq("mult_busy_cycles", 32'(n), 32'd5);
    check_eq("mult_hold", 32'(held), 32'd1);
    check_eq("mult_stall", 32'(sok), 32'd1);
    check_eq("mult_hi", hi, 32'hFFFF_FFFF);
    check_eq("mult_lo", lo, 32'hFFFF_FFF1);
    check_eq("mult_stall_after", 32'(stall), 32'd0);

    md_use = 1'b0;
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, n, held, sok);
    check_eq("multu_busy_cycles", 32'(n), 32'd5);
    check_eq("multu_stall_gated", 32'(sok), 32'd1);
    check_eq("multu_hi", hi, 32'h0000_0001);
    check_eq("multu_lo", lo, 32'hFFFF_FFFE);
    md_use = 1'b1;

    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, n, held, sok);
    check_eq("div_busy_cycles", 32'(n), 32'd10);
    check_eq("div_hold", 32'(held), 32'd1);
    check_eq("div_lo", lo, 32'hFFFF_FFFD);
    check_eq("div_hi", hi, 32'hFFFF_FFFF);

    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, n, held, sok);
    check_eq("divu_busy_cycles", 32'(n), 32'd10);
    check_eq("divu_lo", lo, 32'h7FFF_FFFC);
    check_eq("divu_hi", hi, 32'h0000_0001);

    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, n, held, sok);
    check_eq("divovf_lo", lo, 32'h8000_0000);
    check_eq("divovf_hi", hi, 32'h0000_0000);

    start = 1'b1; md_op = 3'd5; rs = 32'h1234;
    #1;
    check_eq("mthi_stall", 32'(stall), 32'd1);
    tick();
    md_op = 3'd6; rs = 32'h5678;
    tick();
    start = 1'b0; md_op = 3'd0;
    #1;
    check_eq("mt_hi", hi, 32'h1234);
    check_eq("mt_lo", lo, 32'h5678);
    check_eq("mt_busy", 32'(busy), 32'd0);

    run_op(3'd4, 32'h0000_DEAD, 32'd0, n, held, sok);
    check_eq("dz_busy_cycles", 32'(n), 32'd10);
    check_eq("dz_stall", 32'(sok), 32'd1);
    check_eq("dz_hold", 32'(held), 32'd1);
    check_eq("dz_hi", hi, 32'h1234);
    check_eq("dz_lo", lo, 32'h5678);
    check_eq("dz_stall_after", 32'(stall), 32'd0);

    start = 1'b1; md_op = 3'd1; rs = 32'd7; rt = 32'd9;
    tick();
    start = 1'b0; md_op = 3'd0;
    tick(); tick();
    check_eq("rstmid_busy_c3", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_eq("rstmid_busy", 32'(busy), 32'd0);
    check_eq("rstmid_hi", hi, 32'd0);
    check_eq("rstmid_lo", lo, 32'd0);
    check_eq("rstmid_stall", 32'(stall), 32'd0);
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) quiet = 1'b0;
    end
    check_eq("rstmid_no_late_wb", 32'(quiet), 32'd1);

    start = 1'b1; md_op = 3'd5; rs = 32'hAAAA;
    tick();
    check_eq("mthi_then_mult_hi", hi, 32'hAAAA);
    run_op(3'd1, 32'd2, 32'd3, n, held, sok);
    check_eq("b2b1_busy_cycles", 32'(n), 32'd5);
    check_eq("b2b1_lo", lo, 32'd6);
    check_eq("b2b1_hi", hi, 32'd0);
    check_eq("b2b_gap_busy", 32'(busy), 32'd0);
    run_op(3'd1, 32'd4, 32'd5, n, held, sok);
    check_eq("b2b2_busy_cycles", 32'(n), 32'd5);
    check_eq("b2b2_lo", lo, 32'd20);
    check_eq("b2b2_hi", hi, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
